connect4_drop_ctrl: RTL and testbench
=====================================

Name: connect4_drop_ctrl

Overview:
Game-state controller for the Connect-4 VGA display; holds the ROWS x COLS cell occupancy and sequences each move.
- A player's drop request becomes an animated fall, stepped on frame_tick, down to the lowest empty cell.
- The piece is then committed and the turn toggles.
- The pixel renderer reads cell contents through a combinational query port and reads the falling piece through the anim_* outputs.

Parameters:
- ROWS, 6, board rows; row 0 is top.
- COLS, 7, board columns; column 0 is left.
- FALL_FRAMES, 2, frame_ticks per one-row step of the falling piece (>=1).

Ports:
- clock  in  1  system clock
- reset_L  in  1  asynchronous active-low reset
- new_game  in  1  synchronous clear of board/turn; highest priority
- col_sel  in  3  target column for drop
- drop  in  1  drop request, sampled only in IDLE
- undo  in  1  undo request (used only with UNDO_EN)
- frame_tick  in  1  one-cycle pulse per video frame
- query_row  in  3  renderer cell row
- query_col  in  3  renderer cell column
- query_cell  out  2  cell[query_row][query_col]: 00 empty, 01 P1, 10 P2; out-of-range query returns 00; combinational
- anim_valid  out  1  falling piece visible
- anim_row  out  3  falling piece row
- anim_col  out  3  falling piece column
- anim_player  out  2  falling piece owner (01/10)
- turn  out  2  player to move (01/10)
- busy  out  1  state != IDLE
- placed  out  1  one-cycle pulse on commit
- drop_err  out  1  one-cycle pulse on rejected drop
- board_full  out  1  all ROWS*COLS cells occupied

Behaviour:
Reset values (reset_L=0, async): all cells 00; turn=01; state IDLE; per-column heights 0; piece count 0; anim_valid=0; anim_row=0; anim_col=0; anim_player=00; placed=0; drop_err=0; board_full=0.

The controller keeps per-column height h[c] (0..ROWS). The target row for column c is ROWS-1-h[c].

FSM states: IDLE, FALL, PLACE, FULL.

IDLE:
- drop=1 with col_sel>=COLS or h[col_sel]==ROWS -> drop_err pulses on the next cycle; stay in IDLE.
- drop=1 with a valid column -> latch col, target row and player=turn; anim_row=0, anim_col=col, anim_valid=1, frame counter fcnt=0; go to FALL.
- frame_tick is ignored in IDLE.

FALL:
- Each frame_tick increments fcnt.
- On a frame_tick with fcnt==FALL_FRAMES-1: fcnt<=0, then
  - if anim_row==target, go to PLACE;
  - otherwise anim_row<=anim_row+1.
- An empty column (target 5, FALL_FRAMES=2) therefore takes exactly 12 frame_ticks from acceptance to PLACE. A column with 5 pieces takes 2.
- drop and col_sel are ignored in FALL.

PLACE (exactly 1 cycle):
- cell[target][col]<=player; h[col]++; count++; turn toggles 01<->10.
- placed=1 in the following cycle; anim_valid<=0.
- Next state is FULL if count becomes ROWS*COLS, otherwise IDLE.

FULL:
- board_full=1; drop produces drop_err; stay until new_game.

new_game=1, in any state including mid-FALL:
- Next cycle has reset values except placed/drop_err=0.
- Overrides drop/undo in the same cycle.

Other rules:
- drop and undo asserted together in IDLE: drop wins.
- busy is derived combinationally from the state.

Optional Feature:
UNDO_EN
- Defined:
  - Controller stores the last committed column and a last_valid flag, set by PLACE and cleared by reset, new_game and undo.
  - undo=1 in IDLE or FULL with last_valid=1: cell[ROWS-h[last]][last]<=00; h[last]--; count--; turn toggles; last_valid<=0; state<=IDLE; board_full<=0.
  - Only one level of undo is supported; undo with last_valid=0 is ignored.
- Not defined: the undo port is ignored and no last-move storage exists.

Test Plan:
- Reset, then drop col_sel=3; 12 frame_ticks (FALL_FRAMES=2) -> anim_row steps 0..5 every 2 ticks; placed pulses once; query(5,3)=01; turn=10; busy=0.
- Fill column 0 with 6 alternating drops, then a 7th drop at col 0 -> drop_err one cycle; state stays IDLE; turn unchanged; query(0,0)=10.
- drop col_sel=7 -> drop_err; no anim_valid. Drop pulsed during FALL -> ignored; the single move completes normally.
- new_game asserted at the 5th frame_tick of a fall -> next cycle anim_valid=0, all query_cell=00, turn=01, busy=0; no placed pulse.
- Fill the board with 42 drops -> board_full=1 after the last placed; further drop -> drop_err. new_game -> board_full=0.
- (UNDO_EN) drop col 2, then undo -> query(5,2)=00; turn=01. Second undo -> no change.

Source files
------------

// File: rtl/connect4_drop_ctrl.sv
// Connect-4 game-state controller: board occupancy, animated drop, turn sequencing.
// Optional single-level undo is enabled by defining UNDO_EN.
module connect4_drop_ctrl #(
  parameter int ROWS        = 6,
  parameter int COLS        = 7,
  parameter int FALL_FRAMES = 2
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       new_game,
  input  logic [2:0] col_sel,
  input  logic       drop,
  input  logic       undo,
  input  logic       frame_tick,
  input  logic [2:0] query_row,
  input  logic [2:0] query_col,
  output logic [1:0] query_cell,
  output logic       anim_valid,
  output logic [2:0] anim_row,
  output logic [2:0] anim_col,
  output logic [1:0] anim_player,
  output logic [1:0] turn,
  output logic       busy,
  output logic       placed,
  output logic       drop_err,
  output logic       board_full
);

  localparam int HW = $clog2(ROWS + 1);
  localparam int CW = $clog2(ROWS * COLS + 1);
  localparam int FW = (FALL_FRAMES > 1) ? $clog2(FALL_FRAMES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FALL  = 2'd1;
  localparam logic [1:0] S_PLACE = 2'd2;
  localparam logic [1:0] S_FULL  = 2'd3;

  localparam logic [1:0] P1 = 2'b01;
  localparam logic [1:0] P2 = 2'b10;

  logic [1:0]    cell_q [ROWS][COLS];
  logic [1:0]    cell_d [ROWS][COLS];
  logic [HW-1:0] h_q [COLS];
  logic [HW-1:0] h_d [COLS];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [1:0]    state_q, state_d;
  logic [1:0]    turn_q, turn_d;
  logic [2:0]    col_q, col_d;
  logic [2:0]    tgt_q, tgt_d;
  logic [2:0]    arow_q, arow_d;
  logic          avalid_q, avalid_d;
  logic [1:0]    aplayer_q, aplayer_d;
  logic          placed_q, placed_d;
  logic          err_q, err_d;
  logic          full_q, full_d;
`ifdef UNDO_EN
  logic [2:0]    last_q, last_d;
  logic          lastv_q, lastv_d;
`endif

  logic col_ok;
  logic col_full;

  assign col_ok   = int'(col_sel) < COLS;
  assign col_full = col_ok && (int'(h_q[col_sel]) == ROWS);

  always_comb begin
    cell_d    = cell_q;
    h_d       = h_q;
    cnt_d     = cnt_q;
    fcnt_d    = fcnt_q;
    state_d   = state_q;
    turn_d    = turn_q;
    col_d     = col_q;
    tgt_d     = tgt_q;
    arow_d    = arow_q;
    avalid_d  = avalid_q;
    aplayer_d = aplayer_q;
    placed_d  = 1'b0;
    err_d     = 1'b0;
    full_d    = full_q;
`ifdef UNDO_EN
    last_d    = last_q;
    lastv_d   = lastv_q;
`endif
    if (new_game) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          cell_d[r][c] = 2'b00;
      for (int c = 0; c < COLS; c++)
        h_d[c] = '0;
      cnt_d     = '0;
      fcnt_d    = '0;
      state_d   = S_IDLE;
      turn_d    = P1;
      col_d     = '0;
      tgt_d     = '0;
      arow_d    = '0;
      avalid_d  = 1'b0;
      aplayer_d = 2'b00;
      full_d    = 1'b0;
`ifdef UNDO_EN
      last_d    = '0;
      lastv_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_FULL: begin
          if (drop) begin
            if (state_q == S_FULL || !col_ok || col_full) begin
              err_d = 1'b1;
            end else begin
              col_d     = col_sel;
              tgt_d     = 3'(ROWS - 1) - 3'(h_q[col_sel]);
              aplayer_d = turn_q;
              arow_d    = '0;
              avalid_d  = 1'b1;
              fcnt_d    = '0;
              state_d   = S_FALL;
            end
          end
`ifdef UNDO_EN
          else if (undo && lastv_q) begin
            // The last piece sits on top of its column.
            cell_d[3'(ROWS) - 3'(h_q[last_q])][last_q] = 2'b00;
            h_d[last_q] = h_q[last_q] - HW'(1);
            cnt_d   = cnt_q - CW'(1);
            turn_d  = (turn_q == P1) ? P2 : P1;
            lastv_d = 1'b0;
            state_d = S_IDLE;
            full_d  = 1'b0;
          end
`endif
        end
        S_FALL: begin
          if (frame_tick) begin
            if (fcnt_q == FW'(FALL_FRAMES - 1)) begin
              fcnt_d = '0;
              if (arow_q == tgt_q) state_d = S_PLACE;
              else arow_d = arow_q + 3'd1;
            end else begin
              fcnt_d = fcnt_q + FW'(1);
            end
          end
        end
        default: begin
          cell_d[tgt_q][col_q] = aplayer_q;
          h_d[col_q] = h_q[col_q] + HW'(1);
          cnt_d    = cnt_q + CW'(1);
          turn_d   = (turn_q == P1) ? P2 : P1;
          placed_d = 1'b1;
          avalid_d = 1'b0;
`ifdef UNDO_EN
          last_d   = col_q;
          lastv_d  = 1'b1;
`endif
          if (cnt_q + CW'(1) == CW'(ROWS * COLS)) begin
            state_d = S_FULL;
            full_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          cell_q[r][c] <= 2'b00;
      for (int c = 0; c < COLS; c++)
        h_q[c] <= '0;
      cnt_q     <= '0;
      fcnt_q    <= '0;
      state_q   <= S_IDLE;
      turn_q    <= P1;
      col_q     <= '0;
      tgt_q     <= '0;
      arow_q    <= '0;
      avalid_q  <= 1'b0;
      aplayer_q <= 2'b00;
      placed_q  <= 1'b0;
      err_q     <= 1'b0;
      full_q    <= 1'b0;
`ifdef UNDO_EN
      last_q    <= '0;
      lastv_q   <= 1'b0;
`endif
    end else begin
      cell_q    <= cell_d;
      h_q       <= h_d;
      cnt_q     <= cnt_d;
      fcnt_q    <= fcnt_d;
      state_q   <= state_d;
      turn_q    <= turn_d;
      col_q     <= col_d;
      tgt_q     <= tgt_d;
      arow_q    <= arow_d;
      avalid_q  <= avalid_d;
      aplayer_q <= aplayer_d;
      placed_q  <= placed_d;
      err_q     <= err_d;
      full_q    <= full_d;
`ifdef UNDO_EN
      last_q    <= last_d;
      lastv_q   <= lastv_d;
`endif
    end
  end

  always_comb begin
    query_cell = 2'b00;
    if (int'(query_row) < ROWS && int'(query_col) < COLS)
      query_cell = cell_q[query_row][query_col];
  end

`ifndef UNDO_EN
  logic unused_undo;
  assign unused_undo = undo;
`endif

  assign anim_valid  = avalid_q;
  assign anim_row    = arow_q;
  assign anim_col    = col_q;
  assign anim_player = aplayer_q;
  assign turn        = turn_q;
  assign busy        = state_q != S_IDLE;
  assign placed      = placed_q;
  assign drop_err    = err_q;
  assign board_full  = full_q;

endmodule

// File: tb/tb_connect4_drop_ctrl.sv
// Randomized bench for connect4_drop_ctrl against a move-level board model.
// Define UNDO_EN to exercise the undo model as well.
module tb_connect4_drop_ctrl;

  localparam int R  = 6;
  localparam int C  = 7;
  localparam int FF = 2;

  logic       clock = 1'b0;
  logic       reset_L;
  logic       new_game;
  logic [2:0] col_sel;
  logic       drop;
  logic       undo;
  logic       frame_tick;
  logic [2:0] query_row;
  logic [2:0] query_col;
  logic [1:0] query_cell;
  logic       anim_valid;
  logic [2:0] anim_row;
  logic [2:0] anim_col;
  logic [1:0] anim_player;
  logic [1:0] turn;
  logic       busy;
  logic       placed;
  logic       drop_err;
  logic       board_full;

  connect4_drop_ctrl #(.ROWS(R), .COLS(C), .FALL_FRAMES(FF)) dut (
    .clock       (clock),
    .reset_L     (reset_L),
    .new_game    (new_game),
    .col_sel     (col_sel),
    .drop        (drop),
    .undo        (undo),
    .frame_tick  (frame_tick),
    .query_row   (query_row),
    .query_col   (query_col),
    .query_cell  (query_cell),
    .anim_valid  (anim_valid),
    .anim_row    (anim_row),
    .anim_col    (anim_col),
    .anim_player (anim_player),
    .turn        (turn),
    .busy        (busy),
    .placed      (placed),
    .drop_err    (drop_err),
    .board_full  (board_full)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  int brd [R][C];
  int ht [C];
  int mturn;
  int mcnt;
  bit mfull;
  int last_col;
  bit last_v;

  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        brd[r][c] = 0;
    for (int c = 0; c < C; c++) ht[c] = 0;
    mturn  = 1;
    mcnt   = 0;
    mfull  = 0;
    last_v = 0;
  endfunction

  task automatic check_board(string tag);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        query_row = 3'(r);
        query_col = 3'(c);
        #1;
        chk(tag, int'(query_cell), (r < R && c < C) ? brd[r][c] : 0);
      end
    @(negedge clock);
  endtask

  task automatic check_idle_state(string tag);
    chk({tag, "_turn"}, int'(turn), mturn);
    chk({tag, "_busy"}, int'(busy), int'(mfull));
    chk({tag, "_full"}, int'(board_full), int'(mfull));
    chk({tag, "_anim"}, int'(anim_valid), 0);
  endtask

  task automatic do_new_game();
    @(negedge clock);
    new_game = 1'b1;
    drop     = 1'b1;
    undo     = 1'b1;
    @(negedge clock);
    new_game = 1'b0;
    drop     = 1'b0;
    undo     = 1'b0;
    model_clear();
    check_idle_state("ng");
    chk("ng_placed", int'(placed), 0);
    chk("ng_err", int'(drop_err), 0);
  endtask

  // abort_at > 0 asserts new_game together with that frame tick
  task automatic do_drop(int col, int abort_at);
    int tgt;
    int total;
    bit ok;
    ok = !mfull && col < C && ht[col] < R;
    @(negedge clock);
    col_sel = 3'(col);
    drop    = 1'b1;
    undo    = 1'($urandom_range(0, 1));
    @(negedge clock);
    drop = 1'b0;
    undo = 1'b0;
    if (!ok) begin
      chk("err_pulse", int'(drop_err), 1);
      check_idle_state("err");
      @(negedge clock);
      chk("err_clear", int'(drop_err), 0);
      return;
    end
    chk("acc_busy", int'(busy), 1);
    chk("acc_anim", int'(anim_valid), 1);
    chk("acc_row", int'(anim_row), 0);
    chk("acc_col", int'(anim_col), col);
    chk("acc_player", int'(anim_player), mturn);
    chk("acc_err", int'(drop_err), 0);
    tgt   = R - 1 - ht[col];
    total = (tgt + 1) * FF;
    for (int t = 1; t <= total; t++) begin
      repeat ($urandom_range(0, 2)) @(negedge clock);
      frame_tick = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        drop    = 1'b1;
        col_sel = 3'($urandom);
      end
      if (t == abort_at) new_game = 1'b1;
      @(negedge clock);
      frame_tick = 1'b0;
      drop       = 1'b0;
      if (t == abort_at) begin
        new_game = 1'b0;
        model_clear();
        check_idle_state("abort");
        chk("abort_row", int'(anim_row), 0);
        chk("abort_player", int'(anim_player), 0);
        repeat (3) begin
          @(negedge clock);
          chk("abort_placed", int'(placed), 0);
        end
        check_board("abort_cell");
        return;
      end
      chk("fall_row", int'(anim_row), (t == total) ? tgt : t / FF);
      chk("fall_busy", int'(busy), 1);
      chk("fall_placed", int'(placed), 0);
    end
    @(negedge clock);
    brd[tgt][col] = mturn;
    ht[col]++;
    mcnt++;
    mturn    = 3 - mturn;
    mfull    = (mcnt == R * C);
    last_col = col;
    last_v   = 1;
    chk("placed", int'(placed), 1);
    check_idle_state("post");
    @(negedge clock);
    chk("placed_once", int'(placed), 0);
  endtask

  task automatic do_undo();
    @(negedge clock);
    undo = 1'b1;
    @(negedge clock);
    undo = 1'b0;
`ifdef UNDO_EN
    if (last_v) begin
      brd[R - ht[last_col]][last_col] = 0;
      ht[last_col]--;
      mcnt--;
      mturn  = 3 - mturn;
      mfull  = 0;
      last_v = 0;
    end
`endif
    check_idle_state("undo");
    check_board("undo_cell");
  endtask

  initial begin
    int col;
    reset_L    = 1'b0;
    new_game   = 1'b0;
    col_sel    = '0;
    drop       = 1'b0;
    undo       = 1'b0;
    frame_tick = 1'b0;
    query_row  = '0;
    query_col  = '0;
    last_col   = 0;
    model_clear();
    repeat (3) @(negedge clock);
    chk("rst_turn", int'(turn), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_anim", int'(anim_valid), 0);
    chk("rst_row", int'(anim_row), 0);
    chk("rst_col", int'(anim_col), 0);
    chk("rst_player", int'(anim_player), 0);
    chk("rst_placed", int'(placed), 0);
    chk("rst_err", int'(drop_err), 0);
    chk("rst_full", int'(board_full), 0);
    reset_L = 1'b1;
    check_board("rst_cell");

    do_drop(3, 0);
    check_board("first_cell");

    do_new_game();
    for (int i = 0; i < 7; i++) do_drop(0, 0);
    check_board("col0_cell");

    do_drop(7, 0);

    do_drop(2, 0);
    do_undo();
    do_undo();

    do_new_game();
    do_drop(3, 5);

    for (int i = 0; i < 25; i++) begin
      do_drop($urandom_range(0, 7), 0);
      if ($urandom_range(0, 4) == 0) do_undo();
    end
    check_board("rand_cell");

    do_new_game();
    for (int guard = 0; guard < 400 && mcnt < R * C; guard++) begin
      col = $urandom_range(0, C - 1);
      if (ht[col] < R || $urandom_range(0, 5) == 0) do_drop(col, 0);
    end
    chk("fill_count", mcnt, R * C);
    chk("fill_full", int'(board_full), 1);
    check_board("full_cell");
    do_drop($urandom_range(0, C - 1), 0);
    do_undo();
    do_new_game();
    chk("ng_full_clear", int'(board_full), 0);
    check_board("ng_cell");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
